// File: rtl/bram_seq_reader.sv
// Burst reader for the trig/done BRAM read port: one single-word request per address, words queued in a FWFT FIFO.
// Optional request timeout is enabled by defining BRAM_RD_TIMEOUT_EN.
module bram_seq_reader #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [12:0] i_base_addr,
    input  logic [13:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [12:0] o_bram_addr,
    output logic        o_bram_trig,
    input  logic [31:0] i_bram_data,
    input  logic        i_bram_done,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        i_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
        $error("bram_seq_reader: illegal FIFO_DEPTH or TIMEOUT_CYC");
    end

    state_t          state_r;
    state_t          state_nxt_s;
    logic [12:0]     addr_r;
    logic [13:0]     rem_r;
    logic            busy_r;
    logic            done_r;
    logic            trig_r;
    logic [31:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic            accept_s;
    logic            push_s;
    logic            pop_s;
    logic            fifo_space_s;
    logic            timeout_s;

    assign accept_s     = (state_r == ST_IDLE) && i_start;
    assign push_s       = (state_r == ST_REQ) && i_bram_done;
    assign pop_s        = (count_r != {CW{1'b0}}) && i_ready;
    assign fifo_space_s = (count_r < CW'(FIFO_DEPTH));

`ifdef BRAM_RD_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] to_cnt_r;
    logic        err_r;

    assign timeout_s = (state_r == ST_REQ) && !i_bram_done && (to_cnt_r == TO_LAST);

    // Request-age counter; zero outside REQ so every request starts its own count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_cnt_r <= 16'd0;
        end else if (state_r == ST_REQ) begin
            to_cnt_r <= to_cnt_r + 16'd1;
        end else begin
            to_cnt_r <= 16'd0;
        end
    end

    // Sticky timeout flag, cleared by the next accepted command.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_r <= 1'b0;
        end else if (accept_s) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign o_err = err_r;
`else
    assign timeout_s = 1'b0;
    assign o_err     = 1'b0;
`endif

    // Next-state decode; the FIFO space check only happens in GAP so at most one word is ever in flight.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (i_len == 14'd0) ? ST_FIN : ST_GAP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (rem_r == 14'd0) begin
                    state_nxt_s = ST_FIN;
                end else if (fifo_space_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            ST_REQ: begin
                if (i_bram_done) begin
                    state_nxt_s = ST_GAP;
                end else if (timeout_s) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register with the control outputs registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            trig_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_FIN);
            trig_r  <= (state_nxt_s == ST_REQ);
        end
    end

    // Burst address and remaining count; address only moves on the capture edge, when trig also drops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_r <= 13'd0;
            rem_r  <= 14'd0;
        end else if (accept_s) begin
            addr_r <= i_base_addr;
            rem_r  <= i_len;
        end else if (push_s) begin
            addr_r <= addr_r + 13'd1;
            rem_r  <= rem_r - 14'd1;
        end else begin
            addr_r <= addr_r;
            rem_r  <= rem_r;
        end
    end

    // Output FIFO storage and pointers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= i_bram_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_bram_trig = trig_r;
    assign o_bram_addr = addr_r;
    assign o_data      = mem_r[rd_ptr_r];
    assign o_valid     = (count_r != {CW{1'b0}});

endmodule
